// File: rtl/uart_tx_if.sv
// Word handshake and per-frame configuration bus for the parameterised UART transmitter.
interface uart_tx_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
);
  logic             Data_valid;
  logic [WIDTH-1:0] P_data;
  logic             Par_en;
  logic             Par_type;
  logic             Stop2;
  logic [DIV_W-1:0] Baud_div;
  logic             Ready;

  modport master (
    output Data_valid, P_data, Par_en,
    output Par_type, Stop2, Baud_div,
    input  Ready
  );

  modport slave (
    input  Data_valid, P_data, Par_en,
    input  Par_type, Stop2, Baud_div,
    output Ready
  );
endinterface

// File: rtl/uart_tx_param.sv
// UART transmitter: shift register plus one-word holding register,
// per-word parity/stop/baud configuration, back-to-back frames.
module uart_tx_param #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus,
  output logic      Busy,
  output logic      TX_out,
  output logic      Tx_done
);
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pe_q, pe_d;
  logic             par_q, par_d;
  logic             s2_q, s2_d;
  logic [WIDTH-1:0] hdat_q, hdat_d;
  logic [DIV_W-1:0] hdiv_q, hdiv_d;
  logic             hpe_q, hpe_d;
  logic             hpar_q, hpar_d;
  logic             hs2_q, hs2_d;
  logic             hfull_q, hfull_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;

  logic accept, bit_end, last_stop;
  logic frame_end, load_hold, load_new;
  logic in_par;

  assign bus.Ready = !rst && !hfull_q;
  assign accept    = bus.Data_valid && bus.Ready;
  assign in_par    = ^bus.P_data ^ bus.Par_type;
  assign bit_end   = (cnt_q == div_q);
  assign last_stop = (bit_q == {3'b000, s2_q});
  assign frame_end = (state_q == STOP) && bit_end
                     && last_stop;
  assign load_hold = frame_end && hfull_q;
  assign load_new  = accept && ((state_q == IDLE)
                     || (frame_end && !hfull_q));

  assign Busy    = (state_q != IDLE);
  assign TX_out  = tx_q;
  assign Tx_done = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    div_d   = div_q;
    pe_d    = pe_q;
    par_d   = par_q;
    s2_d    = s2_q;
    hdat_d  = hdat_q;
    hdiv_d  = hdiv_q;
    hpe_d   = hpe_q;
    hpar_d  = hpar_q;
    hs2_d   = hs2_q;
    hfull_d = hfull_q;
    tx_d    = tx_q;
    done_d  = frame_end;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 4'(WIDTH - 1)) begin
            bit_d = '0;
            if (pe_q) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          tx_d  = 1'b1;
          if (last_stop) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    // A new frame starts straight after the last stop bit: no idle gap.
    if (load_hold) begin
      state_d = START;
      cnt_d   = '0;
      bit_d   = '0;
      tx_d    = 1'b0;
      sh_d    = hdat_q;
      div_d   = hdiv_q;
      pe_d    = hpe_q;
      par_d   = hpar_q;
      s2_d    = hs2_q;
      hfull_d = 1'b0;
    end else if (load_new) begin
      state_d = START;
      cnt_d   = '0;
      bit_d   = '0;
      tx_d    = 1'b0;
      sh_d    = bus.P_data;
      div_d   = bus.Baud_div;
      pe_d    = bus.Par_en;
      par_d   = in_par;
      s2_d    = bus.Stop2;
    end

    if (accept && !load_new) begin
      hdat_d  = bus.P_data;
      hdiv_d  = bus.Baud_div;
      hpe_d   = bus.Par_en;
      hpar_d  = in_par;
      hs2_d   = bus.Stop2;
      hfull_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      div_q   <= '0;
      pe_q    <= 1'b0;
      par_q   <= 1'b0;
      s2_q    <= 1'b0;
      hdat_q  <= '0;
      hdiv_q  <= '0;
      hpe_q   <= 1'b0;
      hpar_q  <= 1'b0;
      hs2_q   <= 1'b0;
      hfull_q <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      div_q   <= div_d;
      pe_q    <= pe_d;
      par_q   <= par_d;
      s2_q    <= s2_d;
      hdat_q  <= hdat_d;
      hdiv_q  <= hdiv_d;
      hpe_q   <= hpe_d;
      hpar_q  <= hpar_d;
      hs2_q   <= hs2_d;
      hfull_q <= hfull_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param with a per-cycle line scoreboard.
module tb_uart_tx_param;
  localparam int W  = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic Busy, TX_out, Tx_done;

  uart_tx_if #(.WIDTH(W), .DIV_W(DW)) bus();

  uart_tx_param #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .Busy    (Busy),
    .TX_out  (TX_out),
    .Tx_done (Tx_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic tx;
    logic last;
  } exp_t;

  exp_t q[$];
  int   ncmp = 0;
  int   nerr = 0;
  logic last_end = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Line monitor: one expected entry per cycle while a frame is queued.
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("tx_bit", {31'b0, TX_out}, {31'b0, e.tx});
        chk("tx_done", {31'b0, Tx_done}, {31'b0, last_end});
        last_end = e.last;
      end else begin
        chk("idle_tx", {31'b0, TX_out}, 32'd1);
        chk("idle_done", {31'b0, Tx_done}, {31'b0, last_end});
        last_end = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [7:0] d,
                            input logic pe, pt, s2,
                            input logic [15:0] div);
    logic b[$];
    exp_t x;
    b.push_back(1'b0);
    for (int i = 0; i < W; i++) b.push_back(d[i]);
    if (pe) b.push_back(^d ^ pt);
    b.push_back(1'b1);
    if (s2) b.push_back(1'b1);
    for (int j = 0; j < b.size(); j++) begin
      for (int k = 0; k <= int'(div); k++) begin
        x.tx   = b[j];
        x.last = (j == b.size() - 1) && (k == int'(div));
        q.push_back(x);
      end
    end
  endtask

  task automatic send(input logic [7:0] d,
                      input logic pe, pt, s2,
                      input logic [15:0] div,
                      output int waited,
                      output int qpre);
    logic r;
    logic ok;
    ok = 1'b0;
    waited = 0;
    bus.P_data     = d;
    bus.Par_en     = pe;
    bus.Par_type   = pt;
    bus.Stop2      = s2;
    bus.Baud_div   = div;
    bus.Data_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      r = bus.Ready;
      @(posedge clk);
      #1;
      if (r) ok = 1'b1;
      else waited++;
    end
    bus.Data_valid = 1'b0;
    qpre = q.size();
    chk("accept", {31'b0, ok}, 32'd1);
    if (ok) push_frame(d, pe, pt, s2, div);
  endtask

  task automatic wait_done(input int exp_n);
    int n;
    n = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (Tx_done) break;
    end
    chk("done_latency", n, exp_n);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && q.size() > 0; i++) cyc(1);
    chk("drained", q.size(), 0);
    cyc(3);
  endtask

  int w, qp;

  initial begin
    bus.Data_valid = 1'b0;
    bus.P_data     = '0;
    bus.Par_en     = 1'b0;
    bus.Par_type   = 1'b0;
    bus.Stop2      = 1'b0;
    bus.Baud_div   = '0;

    // Reset state
    cyc(3);
    chk("rst_tx", {31'b0, TX_out}, 32'd1);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_ready", {31'b0, bus.Ready}, 32'd0);
    chk("rst_done", {31'b0, Tx_done}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'b0, bus.Ready}, 32'd1);
    cyc(2);

    // 0xA5 even parity, one stop bit
    send(8'hA5, 1'b1, 1'b0, 1'b0, 16'd3, w, qp);
    chk("busy_a5", {31'b0, Busy}, 32'd1);
    wait_done(44);
    cyc(2);
    chk("idle_after_a5", {31'b0, Busy}, 32'd0);
    drain();

    // 0x00 odd parity, two stop bits
    send(8'h00, 1'b1, 1'b1, 1'b1, 16'd3, w, qp);
    wait_done(48);
    drain();

    // Back-to-back via the holding register
    send(8'h55, 1'b0, 1'b0, 1'b0, 16'd3, w, qp);
    cyc(10);
    send(8'h0F, 1'b0, 1'b0, 1'b0, 16'd3, w, qp);
    chk("hold_wait", w, 0);
    chk("ready_low", {31'b0, bus.Ready}, 32'd0);
    send(8'h33, 1'b1, 1'b0, 1'b0, 16'd3, w, qp);
    chk("third_after_xfer", qp, 39);
    drain();

    // Config changes mid-frame do not touch the frame in flight
    send(8'hC3, 1'b1, 1'b0, 1'b0, 16'd3, w, qp);
    cyc(8);
    bus.Baud_div = 16'd1;
    bus.Par_type = 1'b1;
    bus.Stop2    = 1'b1;
    bus.P_data   = 8'hFF;
    cyc(12);
    drain();
    send(8'hC3, 1'b1, 1'b1, 1'b0, 16'd1, w, qp);
    wait_done(22);
    drain();

    // Reset mid-frame with a word buffered
    send(8'h3C, 1'b0, 1'b0, 1'b0, 16'd3, w, qp);
    send(8'h99, 1'b0, 1'b0, 1'b0, 16'd3, w, qp);
    cyc(16);
    rst = 1'b1;
    q.delete();
    last_end = 1'b0;
    cyc(1);
    chk("abort_tx", {31'b0, TX_out}, 32'd1);
    chk("abort_busy", {31'b0, Busy}, 32'd0);
    chk("abort_ready", {31'b0, bus.Ready}, 32'd0);
    chk("abort_done", {31'b0, Tx_done}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_abort", {31'b0, bus.Ready}, 32'd1);
    cyc(60);
    chk("no_buffered_tx", {31'b0, Busy}, 32'd0);

    // Fastest baud, no parity
    send(8'hFF, 1'b0, 1'b0, 1'b0, 16'd0, w, qp);
    wait_done(10);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter: WIDTH, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter: DIV_W, default 16, width of the baud divisor input.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 Data_valid  input  1  word offered on P_data.
REQ-006 P_data  input  WIDTH  parallel word; transmitted LSB first.
REQ-007 Par_en  input  1  1 = parity bit appended after the data bits.
REQ-008 Par_type  input  1  0 = even parity, 1 = odd parity.
REQ-009 Stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 Baud_div  input  DIV_W  bit period minus one, in clk cycles.
REQ-011 Ready  output  1  word can be accepted this cycle.
REQ-012 Busy  output  1  frame in progress.
REQ-013 TX_out  output  1  registered serial line, idle high.
REQ-014 Tx_done  output  1  one-cycle pulse when a frame's last stop bit ends.

Function
REQ-015 Handshake: a word SHALL be accepted on any rising edge where Data_valid=1 and Ready=1; Data_valid with Ready=0 SHALL be ignored, with no loss of the ignored word's state.
REQ-016 P_data, Par_en, Par_type, Stop2 and Baud_div SHALL be captured with the word at acceptance; input changes afterwards SHALL NOT affect that word's frame.
REQ-017 Buffering: one shift register plus one holding register; Ready = !rst && !hold_full (combinational).
REQ-018 If the block is idle, or the current frame's last stop bit ends on the accepting edge, an accepted word SHALL load the shifter directly; otherwise it loads the holding register.
REQ-019 States: IDLE, START, DATA, PARITY, STOP; Busy = (state != IDLE).
REQ-020 Bit counter: counts 0..Baud_div; each bit SHALL last exactly Baud_div+1 cycles; Baud_div=0 gives one cycle per bit.
REQ-021 Start timing: the start bit (TX_out=0) SHALL appear the cycle after the accepting edge.
REQ-022 START to DATA after one bit period.
REQ-023 DATA SHALL emit WIDTH bits, LSB first, then go to PARITY if the captured Par_en=1, else to STOP.
REQ-024 Parity bit = XOR of all data bits when Par_type=0, and its inverse when Par_type=1.
REQ-025 STOP SHALL hold TX_out=1 for 1 bit period, or 2 when the captured Stop2=1.
REQ-026 Frame length = (Baud_div+1) x (2 + WIDTH + Par_en + Stop2) cycles.
REQ-027 When the last stop bit ends, Tx_done SHALL pulse for one cycle.
REQ-028 At that same edge, if the holding register is full, it SHALL transfer to the shifter, START SHALL follow with no idle bit between frames, and Ready SHALL return high.
REQ-029 At that same edge, if the holding register is empty and no word is accepted, the block SHALL go to IDLE.
REQ-030 In IDLE, TX_out SHALL be 1.

Reset
REQ-031 While rst=1, TX_out=1, Busy=0, Ready=0 and Tx_done=0; state=IDLE, counters=0, holding register empty.
REQ-032 rst asserted mid-frame SHALL abort the frame at the next edge: TX_out=1, the buffered word is discarded, no Tx_done.
REQ-033 Ready SHALL be 1 in the first cycle after rst deasserts.

Verification (WIDTH=8, Baud_div=3 unless stated)
REQ-034 0xA5, Par_en=1, Par_type=0, Stop2=0 -> TX_out bits 0, 1,0,1,0,0,1,0,1, 0, 1, each 4 cycles; Tx_done 44 cycles after acceptance; then IDLE.
REQ-035 0x00, Par_en=1, Par_type=1, Stop2=1 -> parity bit 1, two stop bits, 48-cycle frame.
REQ-036 0x55 accepted, then 0x0F offered during its data phase -> 0x0F accepted and Ready goes low; 0x0F's start bit follows 0x55's stop bit with no idle cycle; a third word held on Data_valid is accepted only after the transfer.
REQ-037 Baud_div and Par_type changed mid-frame -> the current frame is unaffected; the next accepted word uses the new values.
REQ-038 rst pulsed during data bit 3 with a word buffered -> TX_out=1 and Busy=0 at the next edge, no Tx_done, buffered word never transmitted, Ready=1 after release.
REQ-039 Baud_div=0, Par_en=0, 0xFF -> 10-cycle frame: 0, eight 1s, 1; Tx_done 10 cycles after acceptance.
